// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RV32I control unit and its datapath.
// Opcodes, ALU controls, controller states and mux selects.
package riscv_pkg;

  localparam int unsigned OP_W    = 7;
  localparam int unsigned ALUC_W  = 3;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned F3_W    = 3;

  localparam logic [OP_W-1:0] OP_LW  = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_R   = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I   = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BEQ = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL = 7'b1101111;

  localparam logic [ALUC_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUC_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALUC_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALUC_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALUC_W-1:0] ALU_SLT = 3'b101;

  localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_REG   = 2'b10;

  localparam logic [SEL_W-1:0] SRCB_WDATA = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b10;

  localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
  localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

  localparam logic [SEL_W-1:0] IMM_I = 2'b00;
  localparam logic [SEL_W-1:0] IMM_S = 2'b01;
  localparam logic [SEL_W-1:0] IMM_B = 2'b10;
  localparam logic [SEL_W-1:0] IMM_J = 2'b11;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, ILLEGAL
  } ctrl_state_t;

  // Immediate format implied by the opcode alone.
  function automatic logic [SEL_W-1:0] imm_sel(input logic [OP_W-1:0] op);
    case (op)
      OP_SW:   imm_sel = IMM_S;
      OP_BEQ:  imm_sel = IMM_B;
      OP_JAL:  imm_sel = IMM_J;
      default: imm_sel = IMM_I;
    endcase
  endfunction

  // funct3 values the ALU path implements (add/sub, slt, or, and).
  function automatic logic alu_f3_ok(input logic [F3_W-1:0] f3);
    alu_f3_ok = (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Instruction/status inputs and control outputs between the controller and datapath.
interface mc_controller_if;
  import riscv_pkg::*;

  logic [OP_W-1:0]   op;
  logic [F3_W-1:0]   funct3;
  logic              funct7b5;
  logic              zero;
  logic              mem_ready;
  logic [ALUC_W-1:0] alu_control;
  logic [SEL_W-1:0]  alu_src_a;
  logic [SEL_W-1:0]  alu_src_b;
  logic [SEL_W-1:0]  result_src;
  logic [SEL_W-1:0]  imm_src;
  logic              adr_src;
  logic              ir_write;
  logic              pc_write;
  logic              reg_write;
  logic              mem_write;
  logic              illegal_instr;
  logic              retire;

  modport master (
    input  op, funct3, funct7b5, zero, mem_ready,
    output alu_control, alu_src_a, alu_src_b, result_src, imm_src, adr_src,
           ir_write, pc_write, reg_write, mem_write, illegal_instr, retire
  );

  modport slave (
    output op, funct3, funct7b5, zero, mem_ready,
    input  alu_control, alu_src_a, alu_src_b, result_src, imm_src, adr_src,
           ir_write, pc_write, reg_write, mem_write, illegal_instr, retire
  );
endinterface

// File: rtl/alu_decoder.sv
// Maps the controller's coarse ALU request plus funct fields to a 3-bit ALU control.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [SEL_W-1:0]  alu_op,
  input  logic [F3_W-1:0]   funct3,
  input  logic              op5,
  input  logic              funct7b5,
  output logic [ALUC_W-1:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // only R-type sub uses bit 30; addi ignores it
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32I control FSM: fetch/decode/execute/memory/writeback sequencing
// with memory-ready stalls; Moore outputs plus mem_ready/zero qualified enables.
module mc_controller
  import riscv_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  mc_controller_if.master bus
);

  ctrl_state_t      state, state_next;
  logic [SEL_W-1:0] alu_op;
  logic             ir_en, pc_update, branch, reg_en, mem_en, ill_en, retire_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next     = state;
    alu_op         = ALUOP_ADD;
    bus.alu_src_a  = SRCA_PC;
    bus.alu_src_b  = SRCB_WDATA;
    bus.result_src = RES_ALUOUT;
    bus.adr_src    = 1'b0;
    ir_en          = 1'b0;
    pc_update      = 1'b0;
    branch         = 1'b0;
    reg_en         = 1'b0;
    mem_en         = 1'b0;
    ill_en         = 1'b0;
    retire_en      = 1'b0;
    case (state)
      FETCH: begin
        bus.alu_src_b  = SRCB_FOUR;
        bus.result_src = RES_ALURESULT;
        ir_en          = bus.mem_ready;
        pc_update      = bus.mem_ready;
        if (bus.mem_ready) state_next = DECODE;
      end
      DECODE: begin
        bus.alu_src_a = SRCA_OLDPC;
        bus.alu_src_b = SRCB_IMM;
        case (bus.op)
          OP_LW, OP_SW: state_next = (bus.funct3 == 3'b010) ? MEMADR : ILLEGAL;
          OP_R:         state_next = alu_f3_ok(bus.funct3) ? EXECUTER : ILLEGAL;
          OP_I:         state_next = alu_f3_ok(bus.funct3) ? EXECUTEI : ILLEGAL;
          OP_BEQ:       state_next = (bus.funct3 == 3'b000) ? BEQ : ILLEGAL;
          OP_JAL:       state_next = JAL;
          default:      state_next = ILLEGAL;
        endcase
      end
      MEMADR: begin
        bus.alu_src_a = SRCA_REG;
        bus.alu_src_b = SRCB_IMM;
        state_next    = (bus.op == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        bus.adr_src = 1'b1;
        if (bus.mem_ready) state_next = MEMWB;
      end
      MEMWB: begin
        bus.result_src = RES_DATA;
        reg_en         = 1'b1;
        retire_en      = 1'b1;
        state_next     = FETCH;
      end
      MEMWRITE: begin
        bus.adr_src = 1'b1;
        mem_en      = 1'b1;
        retire_en   = bus.mem_ready;
        if (bus.mem_ready) state_next = FETCH;
      end
      EXECUTER: begin
        bus.alu_src_a = SRCA_REG;
        alu_op        = ALUOP_FUNCT;
        state_next    = ALUWB;
      end
      EXECUTEI: begin
        bus.alu_src_a = SRCA_REG;
        bus.alu_src_b = SRCB_IMM;
        alu_op        = ALUOP_FUNCT;
        state_next    = ALUWB;
      end
      ALUWB: begin
        reg_en     = 1'b1;
        retire_en  = 1'b1;
        state_next = FETCH;
      end
      BEQ: begin
        bus.alu_src_a = SRCA_REG;
        alu_op        = ALUOP_SUB;
        branch        = 1'b1;
        retire_en     = 1'b1;
        state_next    = FETCH;
      end
      JAL: begin
        bus.alu_src_a = SRCA_OLDPC;
        bus.alu_src_b = SRCB_FOUR;
        pc_update     = 1'b1;
        state_next    = ALUWB;
      end
      ILLEGAL: ill_en = 1'b1;
      default: state_next = FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (bus.funct3),
    .op5         (bus.op[5]),
    .funct7b5    (bus.funct7b5),
    .alu_control (bus.alu_control)
  );

  assign bus.imm_src = imm_sel(bus.op);

  // Enables are forced low straight from rst_n so nothing pulses during reset.
  assign bus.ir_write      = ir_en & rst_n;
  assign bus.pc_write      = (pc_update | (branch & bus.zero)) & rst_n;
  assign bus.reg_write     = reg_en & rst_n;
  assign bus.mem_write     = mem_en & rst_n;
  assign bus.illegal_instr = ill_en & rst_n;
  assign bus.retire        = retire_en & rst_n;

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle RISC-V control unit that sequences fetch, decode, execute, memory and writeback for the RV32I subset the datapath supports (lw, sw, R-type, I-type ALU, beq, jal). It sits directly upstream of `alu`:
- drives its 3-bit `alu_control` and operand-mux selects;
- consumes its `zero` flag for branch resolution.

It also drives register-file, instruction-register, PC and memory enables, and stalls on a memory-ready handshake.

## Interface
Parameters: none. All encodings come from the shared package.

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `op`  in  7  instruction opcode from the instruction register; valid from DECODE onward
- `funct3`  in  3  instruction funct3
- `funct7b5`  in  1  instruction bit 30
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completed the current access this cycle
- `alu_control`  out  3  ADD=000, SUB=001, AND=010, OR=011, SLT=101
- `alu_src_a`  out  2  00 PC, 01 OldPC, 10 A register
- `alu_src_b`  out  2  00 WriteData register, 01 ImmExt, 10 constant 4
- `result_src`  out  2  00 ALUOut, 01 Data register, 10 ALUResult
- `imm_src`  out  2  00 I, 01 S, 10 B, 11 J
- `adr_src`  out  1  0 PC, 1 Result
- `ir_write`  out  1  instruction register load enable
- `pc_write`  out  1  PC load enable
- `reg_write`  out  1  register-file write enable
- `mem_write`  out  1  data memory write enable
- `illegal_instr`  out  1  unsupported instruction seen; sticky
- `retire`  out  1  one-cycle pulse in the last cycle of each instruction

## Operation
States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL, ILLEGAL.

Outputs are Moore, decoded from the state. Exceptions:
- `pc_write` = pc_update | (branch & zero).
- Enables in FETCH, MEMREAD and MEMWRITE are additionally gated by `mem_ready`.

Per-state outputs (unlisted enables are 0):
- FETCH: adr_src 0, alu_src_a 00, alu_src_b 10, ADD, result_src 10. ir_write = pc_update = mem_ready. Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE: alu_src_a 01, alu_src_b 01, ADD (branch target precompute).
  - Next state by opcode: lw 0000011 / sw 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; beq 1100011 -> BEQ; jal 1101111 -> JAL.
  - Goes to ILLEGAL for any other opcode, for lw/sw with funct3≠010, for beq with funct3≠000, or for R/I with funct3 outside {000,010,110,111}.
- MEMADR: alu_src_a 10, alu_src_b 01, ADD. Next state MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: adr_src 1, result_src 00. Holds until mem_ready, then goes to MEMWB.
- MEMWB: result_src 01, reg_write 1 -> FETCH.
- MEMWRITE: adr_src 1, mem_write 1. Holds until mem_ready -> FETCH. mem_write is held high while waiting.
- EXECUTER: alu_src_a 10, alu_src_b 00, funct-decoded op -> ALUWB.
- EXECUTEI: alu_src_a 10, alu_src_b 01, funct-decoded op -> ALUWB.
- ALUWB: result_src 00, reg_write 1 -> FETCH.
- BEQ: alu_src_a 10, alu_src_b 00, SUB, result_src 00, branch 1 -> FETCH.
- JAL: alu_src_a 01, alu_src_b 10, ADD, result_src 00, pc_update 1 -> ALUWB.
- ILLEGAL: all enables 0, illegal_instr 1. Absorbing until reset.

imm_src is decoded from op in every state: I for lw and I-type, S for sw, B for beq, J for jal, 00 otherwise.

Funct decode:
- funct3 000 -> SUB only when op[5] & funct7b5 (R-type sub); ADD otherwise (addi ignores bit 30).
- 010 -> SLT, 110 -> OR, 111 -> AND.

retire is asserted in MEMWB, ALUWB, BEQ, and in MEMWRITE when mem_ready.

## Timing
- Reset: state = FETCH asynchronously. While rst_n is low, ir_write, pc_write, reg_write, mem_write, retire, illegal_instr = 0.
- Deassertion is synchronised externally. The first FETCH edge is the first rising clk edge with rst_n high.
- Latency with mem_ready tied high: beq 3, sw 4, R/I 4, jal 4, lw 5 cycles. Each wait cycle on mem_ready adds 1.
- Reset mid-instruction aborts immediately. No write enable may glitch high during or after the reset assertion.
- Branch: zero is sampled combinationally in BEQ. pc_write in BEQ = zero.

## Structure
- Package `riscv_pkg` holds:
  - opcode constants;
  - ALU control constants (ADD/SUB/AND/OR/SLT), shared with `alu`;
  - state enum `ctrl_state_t`;
  - mux select encodings for alu_src_a/b, result_src and imm_src.
- Sub-module `alu_decoder`: (alu_op[1:0], funct3, op5, funct7b5) -> alu_control. alu_op 00 = ADD, 01 = SUB, 10 = funct decode.
- Top level: state register, next-state logic, output decode.

## Test plan
- add x3,x1,x2 (op 0110011, f3 000, f7b5 0), mem_ready=1:
  - states FETCH, DECODE, EXECUTER, ALUWB;
  - alu_control 000 in EXECUTER;
  - reg_write=1 only in cycle 4; retire pulse in cycle 4.
- sub (f7b5 1) -> alu_control 001. addi with bit30=1 (op 0010011) -> 000. slti f3 010 -> 101.
- beq with zero=1 -> pc_write=1 in cycle 3. With zero=0 -> pc_write=0. Both return to FETCH.
- lw with mem_ready low for 2 cycles in FETCH and 3 in MEMREAD -> 10 total cycles; ir_write only in the mem_ready cycle.
- sw stalled 2 cycles -> mem_write stays 1 for 3 cycles, then FETCH. Opcode 0000000 -> ILLEGAL, illegal_instr=1, no enables until reset.
- rst_n low in MEMWRITE mid-stall -> mem_write drops to 0 asynchronously in the same cycle; after release, FETCH.
